// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, trap causes, FSM states
// and the access legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        CAUSE_NONE         = 2'd0,
        CAUSE_MISALIGNED   = 2'd1,
        CAUSE_ILLEGAL_SIZE = 2'd2,
        CAUSE_TIMEOUT      = 2'd3
    } lsu_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } lsu_state_e;

    // An illegal size takes priority over misalignment when both apply.
    function automatic lsu_cause_e check_access(input lsu_size_e size,
                                                input logic [2:0] addr_lo,
                                                input logic dword_ok);
        lsu_cause_e cause;
        cause = CAUSE_NONE;
        case (size)
            SIZE_HALF:  if (addr_lo[0]) cause = CAUSE_MISALIGNED;
            SIZE_WORD:  if (addr_lo[1:0] != 2'b00) cause = CAUSE_MISALIGNED;
            SIZE_DWORD: begin
                if (!dword_ok) cause = CAUSE_ILLEGAL_SIZE;
                else if (addr_lo != 3'b000) cause = CAUSE_MISALIGNED;
            end
            default: cause = CAUSE_NONE;
        endcase
        return cause;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte mask and store-data shift toward memory,
// load-data shift and sign/zero extension back from memory.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  lsu_size_e          size,
    input  logic [OFF_W-1:0]   offset,
    input  logic               is_unsigned,
    input  logic [XLEN-1:0]    wdata,
    input  logic [XLEN-1:0]    rdata,
    output logic [NB-1:0]      mask,
    output logic [XLEN-1:0]    wdata_aligned,
    output logic [XLEN-1:0]    rdata_aligned
);

    logic [OFF_W+2:0] shamt;
    logic [3:0]       nbytes;
    logic [XLEN-1:0]  rshift;

    assign shamt = {offset, 3'b000};

    always_comb begin
        nbytes        = 4'd1 << size;
        mask          = NB'((16'd1 << nbytes) - 16'd1) << offset;
        wdata_aligned = wdata << shamt;
        rshift        = rdata >> shamt;
        case (size)
            SIZE_BYTE: rdata_aligned = is_unsigned ? XLEN'(rshift[7:0])
                                                   : XLEN'($signed(rshift[7:0]));
            SIZE_HALF: rdata_aligned = is_unsigned ? XLEN'(rshift[15:0])
                                                   : XLEN'($signed(rshift[15:0]));
            SIZE_WORD: rdata_aligned = is_unsigned ? XLEN'(rshift[31:0])
                                                   : XLEN'($signed(rshift[31:0]));
            default:   rdata_aligned = rshift;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one request, checks alignment, issues
// one memory beat, waits for load data with a timeout, and returns a one-cycle response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_rst,

    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_store,
    input  logic [1:0]          i_req_size,
    input  logic                i_req_unsigned,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [XLEN-1:0]     i_req_wdata,
    input  logic [4:0]          i_req_rd,

    output logic                o_mem_valid,
    input  logic                i_mem_ready,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_ren,
    output logic                o_mem_wen,
    output logic [XLEN-1:0]     o_mem_wdata,
    output logic [XLEN/8-1:0]   o_mem_mask,
    input  logic                i_mem_rvalid,
    input  logic [XLEN-1:0]     i_mem_rdata,

    output logic                o_rsp_valid,
    output logic [XLEN-1:0]     o_rsp_rdata,
    output logic [4:0]          o_rsp_rd,
    output logic                o_rsp_trap,
    output logic [1:0]          o_rsp_cause,
    output logic                o_busy
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e        state;
    logic              req_store_q;
    lsu_size_e         req_size_q;
    logic              req_unsigned_q;
    logic [OFF_W-1:0]  req_off_q;
    logic [4:0]        req_rd_q;
    logic [CNT_W-1:0]  wait_cnt;

    lsu_size_e         al_size;
    logic [OFF_W-1:0]  al_off;
    logic              al_unsigned;
    logic [NB-1:0]     al_mask;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_rdata;
    lsu_cause_e        access_cause;
    logic [ADDR_W-1:0] aligned_addr;

    assign o_req_ready  = (state == ST_IDLE);
    assign o_busy       = (state != ST_IDLE);
    assign access_cause = check_access(lsu_size_e'(i_req_size), i_req_addr[2:0], XLEN == 64);
    assign aligned_addr = {i_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // The single aligner serves the incoming request while idle and the captured
    // request afterwards, when it is only needed to steer returning load data.
    always_comb begin
        if (state == ST_IDLE) begin
            al_size     = lsu_size_e'(i_req_size);
            al_off      = i_req_addr[OFF_W-1:0];
            al_unsigned = i_req_unsigned;
        end else begin
            al_size     = req_size_q;
            al_off      = req_off_q;
            al_unsigned = req_unsigned_q;
        end
    end

    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .size          (al_size),
        .offset        (al_off),
        .is_unsigned   (al_unsigned),
        .wdata         (i_req_wdata),
        .rdata         (i_mem_rdata),
        .mask          (al_mask),
        .wdata_aligned (al_wdata),
        .rdata_aligned (al_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            req_store_q    <= 1'b0;
            req_size_q     <= SIZE_BYTE;
            req_unsigned_q <= 1'b0;
            req_off_q      <= '0;
            req_rd_q       <= '0;
            o_mem_valid    <= 1'b0;
            o_mem_addr     <= '0;
            o_mem_ren      <= 1'b0;
            o_mem_wen      <= 1'b0;
            o_mem_wdata    <= '0;
            o_mem_mask     <= '0;
            o_rsp_valid    <= 1'b0;
            o_rsp_rdata    <= '0;
            o_rsp_rd       <= '0;
            o_rsp_trap     <= 1'b0;
            o_rsp_cause    <= CAUSE_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        req_store_q    <= i_req_store;
                        req_size_q     <= lsu_size_e'(i_req_size);
                        req_unsigned_q <= i_req_unsigned;
                        req_off_q      <= i_req_addr[OFF_W-1:0];
                        req_rd_q       <= i_req_rd;
                        if (access_cause != CAUSE_NONE) begin
                            state       <= ST_DONE;
                            o_rsp_valid <= 1'b1;
                            o_rsp_rdata <= '0;
                            o_rsp_rd    <= i_req_rd;
                            o_rsp_trap  <= 1'b1;
                            o_rsp_cause <= access_cause;
                        end else begin
                            state       <= ST_ISSUE;
                            o_mem_valid <= 1'b1;
                            o_mem_addr  <= aligned_addr;
                            o_mem_ren   <= !i_req_store;
                            o_mem_wen   <= i_req_store;
                            o_mem_wdata <= al_wdata;
                            o_mem_mask  <= al_mask;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (i_mem_ready) begin
                        o_mem_valid <= 1'b0;
                        o_mem_addr  <= '0;
                        o_mem_ren   <= 1'b0;
                        o_mem_wen   <= 1'b0;
                        o_mem_wdata <= '0;
                        o_mem_mask  <= '0;
                        if (req_store_q) begin
                            state       <= ST_DONE;
                            o_rsp_valid <= 1'b1;
                            o_rsp_rdata <= '0;
                            o_rsp_rd    <= req_rd_q;
                            o_rsp_trap  <= 1'b0;
                            o_rsp_cause <= CAUSE_NONE;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= '0;
                        end
                    end
                end

                // Load data wins over the timeout if both land on the last WAIT cycle.
                ST_WAIT: begin
                    if (i_mem_rvalid) begin
                        state       <= ST_DONE;
                        o_rsp_valid <= 1'b1;
                        o_rsp_rdata <= al_rdata;
                        o_rsp_rd    <= req_rd_q;
                        o_rsp_trap  <= 1'b0;
                        o_rsp_cause <= CAUSE_NONE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state       <= ST_DONE;
                        o_rsp_valid <= 1'b1;
                        o_rsp_rdata <= '0;
                        o_rsp_rd    <= req_rd_q;
                        o_rsp_trap  <= 1'b1;
                        o_rsp_cause <= CAUSE_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    state       <= ST_IDLE;
                    o_rsp_valid <= 1'b0;
                    o_rsp_rdata <= '0;
                    o_rsp_rd    <= '0;
                    o_rsp_trap  <= 1'b0;
                    o_rsp_cause <= CAUSE_NONE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a 32-bit and a 64-bit instance driven with
// directed and random transactions against an arithmetic reference model.
module tb_load_store_unit;

    localparam int T32 = 4;
    localparam int T64 = 6;

    logic        clk;
    logic        rst;
    logic        sel64;
    logic        req_valid32, req_valid64;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_ready, mem_rvalid;
    logic [63:0] mem_rdata;

    logic        ready32, mvalid32, ren32, wen32, rvalid32, trap32, busy32;
    logic [31:0] maddr32, wdata32, rdata32;
    logic [3:0]  mask32;
    logic [4:0]  rd32;
    logic [1:0]  cause32;
    logic        ready64, mvalid64, ren64, wen64, rvalid64, trap64, busy64;
    logic [31:0] maddr64;
    logic [63:0] wdata64, rdata64;
    logic [7:0]  mask64;
    logic [4:0]  rd64;
    logic [1:0]  cause64;

    int checks   = 0;
    int failures = 0;

    load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(T32)) dut32 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid32), .o_req_ready(ready32), .i_req_store(req_store),
        .i_req_size(req_size), .i_req_unsigned(req_unsigned), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata[31:0]), .i_req_rd(req_rd),
        .o_mem_valid(mvalid32), .i_mem_ready(mem_ready), .o_mem_addr(maddr32),
        .o_mem_ren(ren32), .o_mem_wen(wen32), .o_mem_wdata(wdata32), .o_mem_mask(mask32),
        .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata[31:0]),
        .o_rsp_valid(rvalid32), .o_rsp_rdata(rdata32), .o_rsp_rd(rd32),
        .o_rsp_trap(trap32), .o_rsp_cause(cause32), .o_busy(busy32)
    );

    load_store_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(T64)) dut64 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid64), .o_req_ready(ready64), .i_req_store(req_store),
        .i_req_size(req_size), .i_req_unsigned(req_unsigned), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .i_req_rd(req_rd),
        .o_mem_valid(mvalid64), .i_mem_ready(mem_ready), .o_mem_addr(maddr64),
        .o_mem_ren(ren64), .o_mem_wen(wen64), .o_mem_wdata(wdata64), .o_mem_mask(mask64),
        .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
        .o_rsp_valid(rvalid64), .o_rsp_rdata(rdata64), .o_rsp_rd(rd64),
        .o_rsp_trap(trap64), .o_rsp_cause(cause64), .o_busy(busy64)
    );

    // View of whichever instance the current step is exercising.
    logic        c_ready, c_mvalid, c_ren, c_wen, c_rvalid, c_trap, c_busy;
    logic [63:0] c_maddr, c_wdata, c_rdata, c_mask;
    logic [4:0]  c_rd;
    logic [1:0]  c_cause;
    assign c_ready  = sel64 ? ready64  : ready32;
    assign c_mvalid = sel64 ? mvalid64 : mvalid32;
    assign c_ren    = sel64 ? ren64    : ren32;
    assign c_wen    = sel64 ? wen64    : wen32;
    assign c_rvalid = sel64 ? rvalid64 : rvalid32;
    assign c_trap   = sel64 ? trap64   : trap32;
    assign c_busy   = sel64 ? busy64   : busy32;
    assign c_maddr  = sel64 ? {32'd0, maddr64} : {32'd0, maddr32};
    assign c_wdata  = sel64 ? wdata64  : {32'd0, wdata32};
    assign c_rdata  = sel64 ? rdata64  : {32'd0, rdata32};
    assign c_mask   = sel64 ? {56'd0, mask64} : {60'd0, mask32};
    assign c_rd     = sel64 ? rd64     : rd32;
    assign c_cause  = sel64 ? cause64  : cause32;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Expected behaviour computed with plain byte arithmetic.
    function automatic void refModel(input bit is64, input logic [1:0] size,
                                     input logic [31:0] addr, input logic [63:0] wdata,
                                     input logic [63:0] rdata, input bit uns,
                                     output logic [1:0] cause, output logic [63:0] m_addr,
                                     output logic [63:0] mask, output logic [63:0] wd,
                                     output logic [63:0] rv);
        int nb, wb, off;
        logic [63:0] xmask, v, lim;
        nb    = 1 << size;
        wb    = is64 ? 8 : 4;
        off   = int'(addr % 32'(wb));
        cause = 2'd0;
        if (size == 2'd3 && !is64) cause = 2'd2;
        else if ((addr % 32'(nb)) != 0) cause = 2'd1;
        m_addr = 64'(addr) - 64'(off);
        mask   = ((64'd1 << nb) - 64'd1) << off;
        xmask  = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        wd     = ((wdata & xmask) << (8 * off)) & xmask;
        v      = (rdata & xmask) >> (8 * off);
        if (nb < 8) begin
            lim = (64'd1 << (8 * nb)) - 64'd1;
            v   = v & lim;
            if (!uns && v[8*nb-1]) v = v | ~lim;
        end
        rv = v & xmask;
    endfunction

    // One complete transaction: request, memory beat with rdy_dly stall cycles,
    // load data after rv_dly WAIT cycles (rv_dly >= timeout means never), response.
    task automatic applyStimulus(input bit is64, input bit store, input logic [1:0] size,
                                 input bit uns, input logic [31:0] addr,
                                 input logic [63:0] wdata, input logic [63:0] rdata,
                                 input logic [4:0] rd, input int rdy_dly, input int rv_dly);
        logic [1:0]  e_cause;
        logic [63:0] e_addr, e_mask, e_wdata, e_rdata;
        int          tmo;
        bit          timed_out;
        tmo       = is64 ? T64 : T32;
        timed_out = 1'b0;
        refModel(is64, size, addr, wdata, rdata, uns, e_cause, e_addr, e_mask, e_wdata, e_rdata);
        sel64 = is64;

        @(posedge clk); #1;
        if (is64) req_valid64 = 1'b1; else req_valid32 = 1'b1;
        req_store = store; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(negedge clk);
        checkOutput("req_ready", c_ready, 1);
        checkOutput("mem_valid_at_accept", c_mvalid, 0);
        @(posedge clk); #1;
        req_valid32 = 1'b0; req_valid64 = 1'b0;
        req_addr = $urandom; req_wdata = {$urandom, $urandom};
        req_size = 2'($urandom); req_store = 1'($urandom); req_rd = 5'($urandom);

        if (e_cause != 2'd0) begin
            @(negedge clk);
            checkOutput("trap_rsp_valid", c_rvalid, 1);
            checkOutput("trap_flag", c_trap, 1);
            checkOutput("trap_cause", c_cause, e_cause);
            checkOutput("trap_rdata", c_rdata, 0);
            checkOutput("trap_rd", c_rd, rd);
            checkOutput("trap_no_mem", c_mvalid, 0);
            checkOutput("trap_busy", c_busy, 1);
        end else begin
            for (int i = 0; i <= rdy_dly; i++) begin
                if (i == rdy_dly) mem_ready = 1'b1;
                @(negedge clk);
                checkOutput("mem_valid", c_mvalid, 1);
                checkOutput("mem_ren", c_ren, !store);
                checkOutput("mem_wen", c_wen, store);
                checkOutput("mem_addr", c_maddr, e_addr);
                checkOutput("mem_mask", c_mask, e_mask);
                checkOutput("mem_wdata", c_wdata, e_wdata);
                checkOutput("issue_no_rsp", c_rvalid, 0);
                @(posedge clk); #1;
            end
            mem_ready = 1'b0;
            if (store) begin
                @(negedge clk);
                checkOutput("st_rsp_valid", c_rvalid, 1);
                checkOutput("st_trap", c_trap, 0);
                checkOutput("st_cause", c_cause, 0);
                checkOutput("st_rdata", c_rdata, 0);
                checkOutput("st_rd", c_rd, rd);
                checkOutput("st_mem_released", c_mvalid, 0);
            end else begin
                for (int i = 0; i < tmo; i++) begin
                    if (i == rv_dly) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rdata;
                    end
                    @(negedge clk);
                    checkOutput("wait_no_mem", c_mvalid | c_ren | c_wen, 0);
                    checkOutput("wait_no_rsp", c_rvalid, 0);
                    checkOutput("wait_busy", c_busy, 1);
                    @(posedge clk); #1;
                    mem_rvalid = 1'b0;
                    mem_rdata  = {$urandom, $urandom};
                    if (i == rv_dly) break;
                end
                @(negedge clk);
                checkOutput("ld_rsp_valid", c_rvalid, 1);
                checkOutput("ld_rd", c_rd, rd);
                if (rv_dly < tmo) begin
                    checkOutput("ld_trap", c_trap, 0);
                    checkOutput("ld_cause", c_cause, 0);
                    checkOutput("ld_rdata", c_rdata, e_rdata);
                end else begin
                    timed_out = 1'b1;
                    checkOutput("tmo_trap", c_trap, 1);
                    checkOutput("tmo_cause", c_cause, 3);
                    checkOutput("tmo_rdata", c_rdata, 0);
                end
            end
        end

        @(posedge clk); #1;
        if (timed_out) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
        end
        @(negedge clk);
        checkOutput("rsp_one_cycle", c_rvalid, 0);
        checkOutput("idle_ready", c_ready, 1);
        checkOutput("idle_busy", c_busy, 0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("late_rvalid_ignored", c_rvalid, 0);
    endtask

    initial begin
        bit          r64, rst_store, r_uns;
        logic [1:0]  r_size;
        logic [31:0] r_addr;
        int          r_tmo, r_rv;

        rst = 1'b1; sel64 = 1'b0;
        req_valid32 = 1'b0; req_valid64 = 1'b0; req_store = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        $display("[TB] reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel64 = 1'(s);
            #1;
            checkOutput("rst_ready", c_ready, 1);
            checkOutput("rst_busy", c_busy, 0);
            checkOutput("rst_mem", {c_mvalid, c_ren, c_wen}, 0);
            checkOutput("rst_mem_addr", c_maddr, 0);
            checkOutput("rst_mem_mask", c_mask, 0);
            checkOutput("rst_mem_wdata", c_wdata, 0);
            checkOutput("rst_rsp", {c_rvalid, c_trap, c_cause, c_rd}, 0);
            checkOutput("rst_rsp_rdata", c_rdata, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] directed transactions");
        applyStimulus(0, 0, 2'd0, 0, 32'h1003, 64'h0, 64'h80FF_FFFF, 5'd3, 0, 0);
        applyStimulus(0, 1, 2'd1, 0, 32'h2002, 64'h1234, 64'h0, 5'd4, 3, 0);
        applyStimulus(0, 0, 2'd2, 0, 32'h3001, 64'h0, 64'h0, 5'd5, 0, 0);
        applyStimulus(0, 0, 2'd2, 0, 32'h3004, 64'h0, 64'hDEAD_BEEF, 5'd6, 0, T32);
        applyStimulus(0, 0, 2'd3, 0, 32'h3008, 64'h0, 64'h0, 5'd7, 0, 0);
        applyStimulus(0, 0, 2'd2, 0, 32'h3010, 64'h0, 64'h8765_4321, 5'd8, 1, T32 - 1);
        applyStimulus(1, 0, 2'd3, 0, 32'h4008, 64'h0, 64'h0123_4567_89AB_CDEF, 5'd9, 0, 0);
        applyStimulus(1, 0, 2'd2, 1, 32'h4004, 64'h0, 64'hFFFF_FFFF_0000_0000, 5'd10, 0, 0);
        applyStimulus(1, 1, 2'd3, 0, 32'h4010, 64'hA5A5_5A5A_1234_5678, 64'h0, 5'd11, 0, 0);
        applyStimulus(1, 0, 2'd3, 0, 32'h4014, 64'h0, 64'h0, 5'd12, 0, 0);
        applyStimulus(1, 0, 2'd2, 0, 32'h4020, 64'h0, 64'h0, 5'd13, 0, T64);

        $display("[TB] random transactions");
        for (int n = 0; n < 60; n++) begin
            r64       = 1'($urandom);
            rst_store = 1'($urandom);
            r_uns     = 1'($urandom);
            r_size    = 2'($urandom);
            r_addr    = $urandom;
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~(32'((1 << r_size) - 1));
            r_tmo = r64 ? T64 : T32;
            r_rv  = ($urandom_range(0, 5) == 0) ? r_tmo : int'($urandom_range(0, 2));
            applyStimulus(r64, rst_store, r_size, r_uns, r_addr, {$urandom, $urandom},
                          {$urandom, $urandom}, 5'($urandom), int'($urandom_range(0, 2)), r_rv);
        end

        $display("[TB] reset during WAIT");
        sel64 = 1'b0;
        @(posedge clk); #1;
        req_valid32 = 1'b1; req_store = 1'b0; req_size = 2'd2; req_addr = 32'h5000; req_rd = 5'd17;
        @(posedge clk); #1;
        req_valid32 = 1'b0;
        mem_ready   = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_busy", c_busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222;
        @(negedge clk);
        checkOutput("mid_rst_ready", c_ready, 1);
        checkOutput("mid_rst_busy", c_busy, 0);
        checkOutput("mid_rst_no_rsp", c_rvalid, 0);
        checkOutput("mid_rst_no_mem", c_mvalid, 0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_rst_no_rsp", c_rvalid, 0);
        end

        applyStimulus(0, 0, 2'd1, 1, 32'h6002, 64'h0, 64'hBEEF_0000, 5'd18, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum number of WAIT cycles before a bus-error trap.
REQ-004 SHALL have ports i_clk (in, 1, clock) and i_rst (in, 1, reset); i_rst is synchronous, active-high, on clock i_clk.
REQ-005 SHALL have request ports: i_req_valid (in, 1); o_req_ready (out, 1); i_req_store (in, 1, 1=store, 0=load); i_req_size (in, 2, 0=byte, 1=half, 2=word, 3=dword); i_req_unsigned (in, 1, zero-extend load); i_req_addr (in, ADDR_W, byte address); i_req_wdata (in, XLEN, right-aligned store data); i_req_rd (in, 5, destination tag).
REQ-006 SHALL have memory ports: o_mem_valid (out, 1); i_mem_ready (in, 1); o_mem_addr (out, ADDR_W, XLEN/8-aligned); o_mem_ren (out, 1); o_mem_wen (out, 1); o_mem_wdata (out, XLEN); o_mem_mask (out, XLEN/8); i_mem_rvalid (in, 1); i_mem_rdata (in, XLEN).
REQ-007 SHALL have response ports: o_rsp_valid (out, 1, one-cycle pulse); o_rsp_rdata (out, XLEN); o_rsp_rd (out, 5); o_rsp_trap (out, 1); o_rsp_cause (out, 2, 0=none, 1=misaligned, 2=illegal size, 3=timeout); o_busy (out, 1).

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-009 SHALL drive o_req_ready=1 only in IDLE, and SHALL capture all request fields on i_req_valid&&o_req_ready.
REQ-010 SHALL go from IDLE to DONE with a trap when the address is misaligned (half: addr[0]; word: addr[1:0]; dword: addr[2:0]), or when size=3 with XLEN=32; it SHALL issue no memory traffic in that case.
REQ-011 SHALL otherwise go from IDLE to ISSUE, holding o_mem_valid and all o_mem_* outputs stable until i_mem_ready.
REQ-012 SHALL generate o_mem_mask as (2^(1<<size))-1 shifted left by the byte offset, and o_mem_wdata as i_req_wdata shifted left by 8×offset.
REQ-013 SHALL assert exactly one of o_mem_ren/o_mem_wen together with o_mem_valid, and neither at any other time.
REQ-014 SHALL go from ISSUE to DONE for a store on handshake, and from ISSUE to WAIT for a load.
REQ-015 SHALL sample i_mem_rvalid only in WAIT. A response in WAIT SHALL shift i_mem_rdata right by 8×offset, sign- or zero-extend it from the access width, and go to DONE.
REQ-016 SHALL count WAIT cycles; on count==TIMEOUT with no rvalid it SHALL go to DONE with cause 3. A late rvalid SHALL then be ignored.
REQ-017 SHALL assert o_rsp_valid for exactly one cycle in DONE, then return to IDLE; o_rsp_rdata SHALL be 0 for stores and traps.
REQ-018 SHALL have the following latency with a zero-wait memory: misaligned = accept+1; store = accept+2; load = accept+3 when rvalid arrives the cycle after ready.
REQ-019 SHALL drive o_busy = (state != IDLE).

Reset
REQ-020 SHALL enter IDLE on i_rst and clear the timeout counter; all outputs SHALL be 0 except o_req_ready=1, on the cycle after reset is sampled.
REQ-021 SHALL abandon any in-flight access on reset mid-operation, without a response.

Structure
REQ-022 SHALL take size encodings, cause codes and the FSM state enum from shared package lsu_pkg.
REQ-023 SHALL place the mask, shift and extend logic in a combinational sub-module lsu_align, instantiated once.

Verification
REQ-024 SHALL cover: XLEN=32, lb at 0x1003, rdata=0x80FFFFFF -> mem_addr=0x1000, mask=0b1000, rsp_rdata=0xFFFFFF80.
REQ-025 SHALL cover: sh at 0x2002, wdata=0x1234, ready asserted after 3 cycles -> o_mem_* stable for 3 cycles, wdata=0x12340000, mask=0b1100, rsp at handshake+1.
REQ-026 SHALL cover: lw at 0x3001 -> no o_mem_valid, rsp_trap=1, cause=1 at accept+1.
REQ-027 SHALL cover: TIMEOUT=4, load with no rvalid -> cause=3 after 4 WAIT cycles; a later rvalid produces no response.
REQ-028 SHALL cover: XLEN=64, ld at 0x4008, lwu at 0x4004 with rdata=0xFFFFFFFF_00000000 -> mask=0xFF, then mask=0xF0 and rsp=0x00000000_FFFFFFFF.
REQ-029 SHALL cover: i_rst asserted in WAIT -> IDLE next cycle, no o_rsp_valid, o_req_ready=1.
